// File: rtl/note_glyph_renderer.sv
// note_glyph_renderer: per-pixel note sprite pipeline.
// Maps DrawX/DrawY onto a host-written table of note slots and drives the
// glyph ROM address. It then picks the glyph bit for the current pixel and
// produces note_on and the playhead highlight note_hl.
// Latency is 4 Clk from DrawX/DrawY to note_on/note_hl. rom_data is expected
// to follow the registered rom_addr within the same cycle.
module note_glyph_renderer #(
  parameter int X0          = 64,
  parameter int Y0          = 96,
  parameter int SCALE_SHIFT = 1,
  parameter int NUM_SLOTS   = 32,
  parameter int PITCH_W     = 5
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic                         we,
  input  logic [$clog2(NUM_SLOTS)-1:0] waddr,
  input  logic [PITCH_W+2:0]           wdata,
  input  logic [$clog2(NUM_SLOTS)-1:0] cur_slot,
  output logic [5:0]                   rom_addr,
  input  logic [7:0]                   rom_data,
  output logic                         note_on,
  output logic                         note_hl
);

  localparam int SLOT_W   = $clog2(NUM_SLOTS);
  localparam int ENT_W    = PITCH_W + 3;
  localparam int SPAN_X   = NUM_SLOTS << (3 + SCALE_SHIFT);
  localparam int GLYPH_PX = 8 << SCALE_SHIFT;

  // Note table
  logic [ENT_W-1:0]  r_table [NUM_SLOTS];

  // S0 combinational: horizontal decode of the incoming pixel
  logic [10:0]       w_dx;
  logic              w_in_x;
  logic [SLOT_W-1:0] w_slot;
  logic [2:0]        w_colx;

  // S0 registers
  logic              r0_vld;
  logic              r0_in_x;
  logic [SLOT_W-1:0] r0_slot;
  logic [2:0]        r0_colx;
  logic [9:0]        r0_y;
  logic [SLOT_W-1:0] r0_cur;

  // S1 registers
  logic              r1_vld;
  logic              r1_in_x;
  logic [2:0]        r1_colx;
  logic [9:0]        r1_y;
  logic              r1_match;
  logic [ENT_W-1:0]  r1_entry;

  // S1 combinational: vertical decode against the slot's pitch
  logic [PITCH_W-1:0] w_pitch;
  logic [2:0]         w_code;
  logic [10:0]        w_top;
  logic [10:0]        w_dy;
  logic               w_in_y;
  logic [2:0]         w_row;

  // S2 registers (rom_addr is the address register itself)
  logic              r2_hit;
  logic [2:0]        r2_colx;
  logic              r2_match;

  // S3 combinational: glyph bit for this pixel column
  logic              w_bit;

  // dx is computed at 11 bits so pixels left of X0 show up as negative.
  assign w_dx   = {1'b0, DrawX} - 11'(X0);
  assign w_in_x = ~w_dx[10] && (w_dx < 11'(SPAN_X));
  assign w_slot = w_dx[3 + SCALE_SHIFT +: SLOT_W];
  assign w_colx = w_dx[SCALE_SHIFT +: 3];

  assign w_pitch = r1_entry[ENT_W-1:3];
  assign w_code  = r1_entry[2:0];
  assign w_top   = 11'(Y0) + (11'(w_pitch) << (2 + SCALE_SHIFT));
  assign w_dy    = {1'b0, r1_y} - w_top;
  assign w_in_y  = ~w_dy[10] && (w_dy < 11'(GLYPH_PX));
  assign w_row   = w_dy[SCALE_SHIFT +: 3];

  assign w_bit   = rom_data[3'd7 - r2_colx];

  // Host write port into the note table; reset blanks every slot
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_table[i] <= '0;
      end
    end else if (we) begin
      r_table[waddr] <= wdata;
    end
  end

  // S0: capture the pixel, its horizontal decode and the playhead slot
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r0_vld  <= 1'b0;
      r0_in_x <= 1'b0;
      r0_slot <= '0;
      r0_colx <= '0;
      r0_y    <= '0;
      r0_cur  <= '0;
    end else begin
      r0_vld  <= 1'b1;
      r0_in_x <= w_in_x;
      r0_slot <= w_slot;
      r0_colx <= w_colx;
      r0_y    <= DrawY;
      r0_cur  <= cur_slot;
    end
  end

  // S1: table read (a same-edge write is seen one cycle later)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r1_vld   <= 1'b0;
      r1_in_x  <= 1'b0;
      r1_colx  <= '0;
      r1_y     <= '0;
      r1_match <= 1'b0;
      r1_entry <= '0;
    end else begin
      r1_vld   <= r0_vld;
      r1_in_x  <= r0_in_x;
      r1_colx  <= r0_colx;
      r1_y     <= r0_y;
      r1_match <= (r0_slot == r0_cur);
      r1_entry <= r_table[r0_slot];
    end
  end

  // S2: glyph ROM address and hit qualification
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      r2_hit   <= 1'b0;
      r2_colx  <= '0;
      r2_match <= 1'b0;
    end else begin
      rom_addr <= {w_code, w_row};
      r2_hit   <= r1_vld & r1_in_x & w_in_y & (w_code != 3'd0);
      r2_colx  <= r1_colx;
      r2_match <= r1_match;
    end
  end

  // S3: final pixel flags toward the colour mapper
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      note_on <= 1'b0;
      note_hl <= 1'b0;
    end else begin
      note_on <= r2_hit & w_bit;
      note_hl <= r2_hit & w_bit & r2_match;
    end
  end

endmodule

// File: tb/tb_note_glyph_renderer.sv
// Bench for note_glyph_renderer: directed steps followed by random pixels.
// Expected values come from an arithmetic reference model of the note table
// and the glyph geometry.
module tb_note_glyph_renderer;

  logic       Clk;
  logic       Reset;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [4:0] cur_slot;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       note_on;
  logic       note_hl;

  note_glyph_renderer #(
    .X0(64), .Y0(96), .SCALE_SHIFT(1), .NUM_SLOTS(32), .PITCH_W(5)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .we(we), .waddr(waddr), .wdata(wdata), .cur_slot(cur_slot),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .note_on(note_on), .note_hl(note_hl)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Glyph ROM model: data follows the registered address
  logic [7:0] rom [64];
  assign rom_data = rom[rom_addr];

  typedef struct {
    bit         on;
    bit         hl;
    bit         hit;
    logic [5:0] addr;
  } exp_t;

  exp_t q[$];
  int   tbl [32];
  int   nasserts = 0;
  int   nfail    = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    nasserts++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: a pixel lands in 16x16 cells starting at (64, 96 + pitch*8)
  function automatic exp_t model(input int x, input int y, input int cs);
    exp_t e;
    int slot, colx, pitch, code, top, row;
    e.on = 0; e.hl = 0; e.hit = 0; e.addr = '0;
    if (x < 64 || x >= 64 + 32 * 16) return e;
    slot  = (x - 64) / 16;
    colx  = ((x - 64) / 2) % 8;
    pitch = tbl[slot] / 8;
    code  = tbl[slot] % 8;
    if (code == 0) return e;
    top = 96 + pitch * 8;
    if (y < top || y >= top + 16) return e;
    row    = (y - top) / 2;
    e.hit  = 1;
    e.addr = 6'(code * 8 + row);
    e.on   = ((rom[code * 8 + row] >> (7 - colx)) & 8'h01) != 0;
    e.hl   = e.on && (slot == cs);
    return e;
  endfunction

  // One pixel per cycle; results due now are checked before driving the next
  task automatic step(input int x, input int y, input int cs,
                      input bit w, input int wa, input int wd);
    exp_t e;
    if (q.size() == 4) begin
      e = q.pop_front();
      chk("note_on", {7'd0, note_on}, {7'd0, e.on});
      chk("note_hl", {7'd0, note_hl}, {7'd0, e.hl});
    end
    if (q.size() == 3 && q[0].hit) chk("rom_addr", {2'd0, rom_addr}, {2'd0, q[0].addr});
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    cur_slot = 5'(cs);
    we       = w;
    waddr    = 5'(wa);
    wdata    = 8'(wd);
    if (w) tbl[wa] = wd;
    q.push_back(model(x, y, cs));
    @(negedge Clk);
  endtask

  task automatic px(input int x, input int y, input int cs);
    step(x, y, cs, 1'b0, 0, 0);
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) px(0, 0, 0);
  endtask

  task automatic load_glyph(input int code, input logic [63:0] g);
    for (int r = 0; r < 8; r++) rom[code * 8 + r] = g[63 - 8 * r -: 8];
  endtask

  initial begin
    load_glyph(0, 64'h0000000000000000);
    load_glyph(1, 64'h003C7E7E7E7E3C00);
    load_glyph(2, 64'h00007E81817E0000);
    load_glyph(3, 64'h183C7EFFFF7E3C18);
    for (int c = 4; c < 8; c++)
      for (int r = 0; r < 8; r++) rom[c * 8 + r] = 8'((c * 29 + r * 53) ^ 8'hA5);
    for (int i = 0; i < 32; i++) tbl[i] = 0;

    Reset = 1'b1; DrawX = '0; DrawY = '0; we = 1'b0;
    waddr = '0; wdata = '0; cur_slot = '0;

    // 1) reset state, then an empty table renders nothing
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_rom_addr", {2'd0, rom_addr}, 8'd0);
    chk("rst_note_on", {7'd0, note_on}, 8'd0);
    chk("rst_note_hl", {7'd0, note_hl}, 8'd0);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) px($urandom_range(0, 1023), $urandom_range(0, 1023), 0);
    flush();

    // 2) slot 0 = {pitch 0, code 1}
    step(0, 0, 0, 1'b1, 0, 8'h01);
    px(70, 100, 0);
    px(64, 100, 0);
    flush();

    // 3) slot 3 = {pitch 2, code 2}, playhead on and off slot 3
    step(0, 0, 3, 1'b1, 3, (2 << 3) | 2);
    px(112, 118, 3);
    px(112, 118, 4);
    flush();

    // 4) horizontal edges, last slot, pitch 31 near the bottom
    step(0, 0, 0, 1'b1, 31, 8'h03);
    step(0, 0, 0, 1'b1, 7, (31 << 3) | 3);
    px(63, 100, 0);
    px(64, 100, 0);
    px(575, 102, 31);
    px(576, 102, 31);
    px(1023, 102, 0);
    for (int yy = 340; yy < 480; yy += 7) px(64 + 7 * 16 + 6, yy, 7);
    px(64 + 7 * 16 + 6, 359, 7);
    px(64 + 7 * 16 + 6, 360, 7);
    px(64 + 7 * 16 + 6, 1023, 7);
    flush();

    // 5) same-cycle write and read of slot 5
    px(150, 102, 5);
    step(150, 102, 5, 1'b1, 5, 8'h03);
    px(150, 102, 5);
    flush();

    // random pixels with occasional table writes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        step($urandom_range(40, 600), $urandom_range(80, 400), $urandom_range(0, 31),
             1'b1, $urandom_range(0, 31), $urandom_range(0, 255));
      else
        px($urandom_range(40, 600), $urandom_range(80, 400), $urandom_range(0, 31));
    end
    flush();

    // 6) reset mid-stream while hits are in flight
    step(0, 0, 0, 1'b1, 0, 8'h01);
    px(70, 100, 0);
    px(70, 100, 0);
    px(70, 100, 0);
    px(70, 100, 0);
    Reset = 1'b1;
    #1;
    chk("midrst_note_on", {7'd0, note_on}, 8'd0);
    chk("midrst_note_hl", {7'd0, note_hl}, 8'd0);
    chk("midrst_rom_addr", {2'd0, rom_addr}, 8'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) tbl[i] = 0;
    q.delete();
    px(70, 100, 0);
    step(70, 100, 0, 1'b1, 0, 8'h01);
    px(70, 100, 0);
    flush();
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule
